// File: rtl/stat_regs_pkg.sv
// rtl/stat_regs_pkg.sv - shared constants, state type and width helpers for the status register bank
package stat_regs_pkg;

  // Bit of master_data that arms auto-report for the addressed channel
  localparam int CMD_AUTO_BIT = 0;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_PEND = 1'b1
  } ch_state_e;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Byte pointer width: at least one bit even for single-byte words
  function automatic int ptr_width(input int bytes);
    return (clog2(bytes) < 1) ? 1 : clog2(bytes);
  endfunction

endpackage

// File: rtl/stat_regs_rd_if.sv
// rtl/stat_regs_rd_if.sv - bus-side signal bundle of the status register bank
interface stat_regs_rd_if #(
  parameter int N     = 2,
  parameter int BYTES = 1
);
  logic [7:0]           master_data;
  logic [N-1:0]         valid_bus;
  logic [N-1:0]         rdreq_bus;
  logic [N-1:0]         have_msg_bus;
  logic [N*8-1:0]       slave_data_bus;
  logic [N*8-1:0]       len_bus;
  logic [N*BYTES*8-1:0] status_in;

  modport master (
    output master_data, valid_bus, rdreq_bus, status_in,
    input  have_msg_bus, slave_data_bus, len_bus
  );

  modport slave (
    input  master_data, valid_bus, rdreq_bus, status_in,
    output have_msg_bus, slave_data_bus, len_bus
  );
endinterface

// File: rtl/stat_reg_ch.sv
// rtl/stat_reg_ch.sv - one status channel: synchroniser, snapshot, byte pointer and pending state
module stat_reg_ch
  import stat_regs_pkg::*;
#(
  parameter int BYTES       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               valid_i,
  input  logic               rdreq_i,
  input  logic               arm_cmd_i,
  input  logic [BYTES*8-1:0] status_i,
  output logic               have_msg_o,
  output logic [7:0]         data_o
);

  // SYNC_STAGES = 0 still gets one register stage
  localparam int STG = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;
  localparam int PW  = ptr_width(BYTES);
  localparam logic [PW-1:0] LAST = PW'(BYTES - 1);

  typedef logic [BYTES-1:0][7:0] word_t;

  word_t         sync_q [STG];
  word_t         sync_w;
  word_t         snap_q, snap_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          arm_q, arm_d;
  ch_state_e     state_q, state_d;

  // Shift raw status through the synchroniser chain
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int s = 0; s < STG; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= status_i;
      for (int s = 1; s < STG; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_w = sync_q[STG-1];

  // Channel state, pointer, snapshot and arm registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= CH_IDLE;
      ptr_q   <= '0;
      snap_q  <= '0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      snap_q  <= snap_d;
      arm_q   <= arm_d;
    end
  end

  // Next state: a request recaptures unconditionally, then reads, then auto-report
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    snap_d  = snap_q;
    arm_d   = arm_q;
    if (valid_i) begin
      snap_d  = sync_w;
      ptr_d   = '0;
      state_d = CH_PEND;
      arm_d   = arm_cmd_i;
    end else begin
      case (state_q)
        CH_PEND: begin
          if (rdreq_i) begin
            if (ptr_q == LAST) begin
              ptr_d   = '0;
              state_d = CH_IDLE;
            end else begin
              ptr_d = ptr_q + PW'(1);
            end
          end
        end
        default: begin
          // Changes made while pending are caught here against the old snapshot
          if (arm_q && (sync_w != snap_q)) begin
            snap_d  = sync_w;
            ptr_d   = '0;
            state_d = CH_PEND;
          end
        end
      endcase
    end
  end

  assign have_msg_o = (state_q == CH_PEND);

  if (BYTES == 1) begin : g_single
    logic unused_ptr;
    assign unused_ptr = ^ptr_q;
    assign data_o     = snap_q[0];
  end else begin : g_multi
    assign data_o = snap_q[ptr_q];
  end

endmodule

// File: rtl/stat_regs_rd.sv
// rtl/stat_regs_rd.sv - N-channel read-only status register bank top
module stat_regs_rd
  import stat_regs_pkg::*;
#(
  parameter int N           = 2,
  parameter int BYTES       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          n_rst,
  stat_regs_rd_if.slave bus
);

  // Only the auto-report bit of the command byte carries meaning
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^bus.master_data[7:1];

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign bus.len_bus[i*8 +: 8] = 8'(BYTES);

    stat_reg_ch #(
      .BYTES       (BYTES),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk        (clk),
      .n_rst      (n_rst),
      .valid_i    (bus.valid_bus[i]),
      .rdreq_i    (bus.rdreq_bus[i]),
      .arm_cmd_i  (bus.master_data[CMD_AUTO_BIT]),
      .status_i   (bus.status_in[i*BYTES*8 +: BYTES*8]),
      .have_msg_o (bus.have_msg_bus[i]),
      .data_o     (bus.slave_data_bus[i*8 +: 8])
    );
  end

endmodule

// File: tb/tb_stat_regs_rd.sv
// tb/tb_stat_regs_rd.sv - self-checking bench for stat_regs_rd (4-byte/2-stage and 1-byte/0-stage builds)
module tb_stat_regs_rd;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  stat_regs_rd_if #(.N(2), .BYTES(4)) ifa ();
  stat_regs_rd_if #(.N(2), .BYTES(1)) ifb ();

  stat_regs_rd #(.N(2), .BYTES(4), .SYNC_STAGES(2)) dut_a (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (ifa)
  );

  stat_regs_rd #(.N(2), .BYTES(1), .SYNC_STAGES(0)) dut_b (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (ifb)
  );

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  logic [7:0] t2_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bench view of the two builds: d=0 is the 4-byte one, d=1 the 1-byte one
  function automatic int nbytes(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int nstg(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic logic [1:0] in_valid(input int d);
    return (d == 0) ? ifa.valid_bus : ifb.valid_bus;
  endfunction

  function automatic logic [1:0] in_rdreq(input int d);
    return (d == 0) ? ifa.rdreq_bus : ifb.rdreq_bus;
  endfunction

  function automatic logic in_arm(input int d);
    return (d == 0) ? ifa.master_data[0] : ifb.master_data[0];
  endfunction

  function automatic logic [63:0] in_status(input int d);
    return (d == 0) ? ifa.status_in : {48'h0, ifb.status_in};
  endfunction

  function automatic logic [1:0] out_have(input int d);
    return (d == 0) ? ifa.have_msg_bus : ifb.have_msg_bus;
  endfunction

  function automatic logic [15:0] out_data(input int d);
    return (d == 0) ? ifa.slave_data_bus : ifb.slave_data_bus;
  endfunction

  // Model: each channel holds the queue of bytes still owed to the master
  logic [63:0] hist  [2][2];
  logic [31:0] msnap [2][2];
  bit          marm  [2][2];
  logic [7:0]  mq    [2][2][$];

  always @(posedge clk or negedge n_rst) begin : model
    logic [63:0] h;
    logic [31:0] sy;
    logic [1:0]  v, r;
    if (!n_rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 2; c++) begin
          msnap[d][c] = '0;
          marm[d][c]  = 1'b0;
          mq[d][c].delete();
          hist[d][c]  = '0;
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        h = hist[d][nstg(d)-1];
        v = in_valid(d);
        r = in_rdreq(d);
        for (int c = 0; c < 2; c++) begin
          sy = 32'(h >> (c * nbytes(d) * 8));
          if (nbytes(d) == 1) sy = sy & 32'hFF;
          if (v[c]) begin
            msnap[d][c] = sy;
            marm[d][c]  = in_arm(d);
            mq[d][c].delete();
            for (int b = 0; b < nbytes(d); b++) mq[d][c].push_back(sy[b*8 +: 8]);
          end else if (mq[d][c].size() != 0) begin
            if (r[c]) void'(mq[d][c].pop_front());
          end else if (marm[d][c] && (sy != msnap[d][c])) begin
            msnap[d][c] = sy;
            for (int b = 0; b < nbytes(d); b++) mq[d][c].push_back(sy[b*8 +: 8]);
          end
        end
        hist[d][1] = hist[d][0];
        hist[d][0] = in_status(d);
      end
    end
  end

  // Per-cycle comparison of every channel of both builds against the model
  always @(negedge clk) begin : compare
    logic [1:0]  hv;
    logic [15:0] dv;
    logic        eh;
    logic [7:0]  ed;
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        hv = out_have(d);
        dv = out_data(d);
        for (int c = 0; c < 2; c++) begin
          eh = (mq[d][c].size() != 0);
          ed = eh ? mq[d][c][0] : msnap[d][c][7:0];
          chk($sformatf("model_have_d%0d_c%0d", d, c), hv[c], eh);
          chk($sformatf("model_data_d%0d_c%0d", d, c), dv[c*8 +: 8], ed);
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_a(input logic [1:0] m);
    ifa.rdreq_bus = m;
    cyc();
    ifa.rdreq_bus = '0;
  endtask

  task automatic vld_a(input logic [1:0] m, input logic [7:0] md);
    ifa.master_data = md;
    ifa.valid_bus   = m;
    cyc();
    ifa.valid_bus   = '0;
    ifa.master_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0;
    ifa.master_data = '0; ifa.valid_bus = '0; ifa.rdreq_bus = '0; ifa.status_in = '0;
    ifb.master_data = '0; ifb.valid_bus = '0; ifb.rdreq_bus = '0; ifb.status_in = 16'h00A5;
    cyc(3);
    chk("rst_have_a", ifa.have_msg_bus, 2'b00);
    chk("rst_have_b", ifb.have_msg_bus, 2'b00);
    chk("rst_data_a", ifa.slave_data_bus, 16'h0000);
    chk("rst_data_b", ifb.slave_data_bus, 16'h0000);
    n_rst = 1'b1;
    cyc(2);
    cmp_en = 1'b1;
    chk("len_a", ifa.len_bus, 16'h0404);
    chk("len_b", ifb.len_bus, 16'h0101);

    // 1-byte build: capture, then a single read ends the message
    ifb.valid_bus = 2'b01;
    cyc();
    ifb.valid_bus = '0;
    chk("t1_have", ifb.have_msg_bus, 2'b01);
    chk("t1_byte", ifb.slave_data_bus[7:0], 8'hA5);
    ifb.rdreq_bus = 2'b01;
    cyc();
    ifb.rdreq_bus = '0;
    chk("t1_clear", ifb.have_msg_bus, 2'b00);

    // 4-byte readout on channel 1
    ifa.status_in = 64'h44332211_00000000;
    cyc(3);
    vld_a(2'b10, 8'h00);
    chk("t2_have", ifa.have_msg_bus, 2'b10);
    chk("t2_byte0", ifa.slave_data_bus[15:8], t2_exp[0]);
    for (int k = 1; k < 4; k++) begin
      rd_a(2'b10);
      chk($sformatf("t2_byte%0d", k), ifa.slave_data_bus[15:8], t2_exp[k]);
      chk($sformatf("t2_have%0d", k), ifa.have_msg_bus, 2'b10);
    end
    rd_a(2'b10);
    chk("t2_done", ifa.have_msg_bus, 2'b00);

    // Auto-report armed, then disarmed
    ifa.status_in[31:0] = 32'h05;
    cyc(3);
    vld_a(2'b01, 8'h01);
    chk("t3_byte", ifa.slave_data_bus[7:0], 8'h05);
    repeat (4) rd_a(2'b01);
    chk("t3_idle", ifa.have_msg_bus, 2'b00);
    ifa.status_in[31:0] = 32'h06;
    cyc(2);
    chk("t3_not_yet", ifa.have_msg_bus, 2'b00);
    cyc();
    chk("t3_report", ifa.have_msg_bus, 2'b01);
    chk("t3_report_byte", ifa.slave_data_bus[7:0], 8'h06);
    repeat (4) rd_a(2'b01);
    vld_a(2'b01, 8'h00);
    repeat (4) rd_a(2'b01);
    ifa.status_in[31:0] = 32'h07;
    cyc(6);
    chk("t3_disarmed", ifa.have_msg_bus, 2'b00);

    // Simultaneous reads; valid colliding with the last-byte read
    vld_a(2'b10, 8'h00);
    repeat (4) rd_a(2'b11);
    chk("t4_both_idle", ifa.have_msg_bus, 2'b00);
    chk("t4_ch0_byte", ifa.slave_data_bus[7:0], 8'h06);
    vld_a(2'b01, 8'h00);
    repeat (3) rd_a(2'b01);
    ifa.status_in[31:0] = 32'h0108;
    cyc(3);
    ifa.valid_bus = 2'b01;
    ifa.rdreq_bus = 2'b01;
    cyc();
    ifa.valid_bus = '0;
    ifa.rdreq_bus = '0;
    chk("t4_restart_have", ifa.have_msg_bus, 2'b01);
    chk("t4_restart_byte", ifa.slave_data_bus[7:0], 8'h08);
    rd_a(2'b01);
    chk("t4_ptr1", ifa.slave_data_bus[7:0], 8'h01);
    repeat (3) rd_a(2'b01);
    chk("t4_done", ifa.have_msg_bus, 2'b00);

    // Changes while pending: one report with the latest value, none if restored
    ifa.status_in[31:0] = 32'h10;
    cyc(3);
    vld_a(2'b01, 8'h01);
    ifa.status_in[31:0] = 32'h20;
    cyc(4);
    ifa.status_in[31:0] = 32'h30;
    cyc(4);
    chk("t5_pend_hold", ifa.slave_data_bus[7:0], 8'h10);
    repeat (4) rd_a(2'b01);
    chk("t5_gap", ifa.have_msg_bus, 2'b00);
    cyc();
    chk("t5_report", ifa.have_msg_bus, 2'b01);
    chk("t5_report_byte", ifa.slave_data_bus[7:0], 8'h30);
    repeat (4) rd_a(2'b01);
    vld_a(2'b01, 8'h01);
    ifa.status_in[31:0] = 32'h40;
    cyc(4);
    ifa.status_in[31:0] = 32'h30;
    cyc(4);
    repeat (4) rd_a(2'b01);
    cyc(3);
    chk("t5_no_report", ifa.have_msg_bus, 2'b00);

    // Reset during readout clears everything including arm
    ifa.status_in[31:0] = 32'hDDCCBBAA;
    cyc(3);
    vld_a(2'b01, 8'h01);
    rd_a(2'b01);
    rd_a(2'b01);
    chk("t6_ptr2", ifa.slave_data_bus[7:0], 8'hCC);
    #2;
    n_rst = 1'b0;
    #1;
    chk("t6_rst_have_a", ifa.have_msg_bus, 2'b00);
    chk("t6_rst_data_a", ifa.slave_data_bus, 16'h0000);
    chk("t6_rst_have_b", ifb.have_msg_bus, 2'b00);
    chk("t6_rst_data_b", ifb.slave_data_bus, 16'h0000);
    @(negedge clk);
    n_rst = 1'b1;
    ifa.status_in[31:0] = 32'h12;
    cyc(6);
    chk("t6_no_auto", ifa.have_msg_bus, 2'b00);
    vld_a(2'b01, 8'h01);
    chk("t6_capture", ifa.slave_data_bus[7:0], 8'h12);
    repeat (4) rd_a(2'b01);
    ifa.status_in[31:0] = 32'h13;
    cyc(3);
    chk("t6_rearmed", ifa.have_msg_bus, 2'b01);
    chk("t6_rearmed_byte", ifa.slave_data_bus[7:0], 8'h13);
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
